// File: rtl/ir_beacon_detect_if.sv
// ir_beacon_detect_if: bundles the raw IR lines and the detector results.
//   ir_raw      : raw asynchronous receiver outputs, one bit per channel
//   IR          : registered beacon-present flags
//   window_done : one-cycle pulse at each window evaluation
//   last_count  : edge counts of the last window, ch0 low, ch1 high
// master is the detector side, slave is the consumer/driver side.
interface ir_beacon_detect_if #(
    parameter int CNT_W = 8
);
    logic [1:0]         ir_raw;
    logic [1:0]         IR;
    logic               window_done;
    logic [2*CNT_W-1:0] last_count;

    modport master (
        input  ir_raw,
        output IR,
        output window_done,
        output last_count
    );

    modport slave (
        output ir_raw,
        input  IR,
        input  window_done,
        input  last_count
    );
endinterface

// File: rtl/ir_beacon_detect.sv
// ir_beacon_detect: measures IR pulse rate per channel over a gate window and
// applies hit/miss hysteresis to produce the beacon-present flags.
//   clk   : system clock
//   reset : synchronous, active-low reset
//   bus   : master side of ir_beacon_detect_if (ir_raw in; IR, window_done,
//           last_count out)
module ir_beacon_detect #(
    parameter int GATE_CYCLES = 100000,
    parameter int CNT_W       = 8,
    parameter int EDGE_MIN    = 4,
    parameter int EDGE_MAX    = 8,
    parameter int HITS_REQ    = 3,
    parameter int MISS_REQ    = 3
) (
    input  logic                clk,
    input  logic                reset,
    ir_beacon_detect_if.master  bus
);
    localparam int WW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [WW-1:0]    WLAST = WW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMAX  = '1;
    localparam logic [CNT_W-1:0] EMIN  = CNT_W'(EDGE_MIN);
    localparam logic [CNT_W-1:0] EMAX  = CNT_W'(EDGE_MAX);
    localparam logic [3:0]       HREQ  = 4'(HITS_REQ);
    localparam logic [3:0]       MREQ  = 4'(MISS_REQ);

    localparam logic [1:0] ABSENT  = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;
    localparam logic [1:0] LOSING  = 2'd3;

    logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [WW-1:0]         wcnt_q, wcnt_d;
    logic [1:0][CNT_W-1:0] ecnt_q, ecnt_d, last_q, last_d, total;
    logic [1:0][1:0]       state_q, state_d;
    logic [1:0][3:0]       streak_q, streak_d, streak_inc;
    logic [1:0]            edge_det, hit;
    logic                  wend, done_q, done_d;

    always_comb begin
        sync1_d  = bus.ir_raw;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        edge_det = sync2_q & ~prev_q;
        wend     = wcnt_q == WLAST;
        wcnt_d   = wend ? '0 : wcnt_q + 1'b1;
        done_d   = wend;
        for (int c = 0; c < 2; c++) begin
            // total is the saturating count including this cycle's edge; it also
            // serves as the next ecnt so an edge in the last cycle stays in window
            total[c]      = (ecnt_q[c] == CMAX) ? CMAX : ecnt_q[c] + CNT_W'(edge_det[c]);
            hit[c]        = total[c] >= EMIN && total[c] <= EMAX;
            ecnt_d[c]     = wend ? '0 : total[c];
            last_d[c]     = wend ? total[c] : last_q[c];
            streak_inc[c] = streak_q[c] + 4'd1;
            state_d[c]    = state_q[c];
            streak_d[c]   = streak_q[c];
            if (wend) begin
                case (state_q[c])
                    ABSENT: begin
                        state_d[c]  = hit[c] ? ACQUIRE : ABSENT;
                        streak_d[c] = hit[c] ? 4'd1 : 4'd0;
                    end
                    ACQUIRE: begin
                        state_d[c]  = !hit[c] ? ABSENT : (streak_inc[c] == HREQ) ? PRESENT : ACQUIRE;
                        streak_d[c] = (hit[c] && streak_inc[c] != HREQ) ? streak_inc[c] : 4'd0;
                    end
                    PRESENT: begin
                        state_d[c]  = hit[c] ? PRESENT : LOSING;
                        streak_d[c] = hit[c] ? 4'd0 : 4'd1;
                    end
                    default: begin
                        state_d[c]  = hit[c] ? PRESENT : (streak_inc[c] == MREQ) ? ABSENT : LOSING;
                        streak_d[c] = (!hit[c] && streak_inc[c] != MREQ) ? streak_inc[c] : 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            wcnt_q   <= '0;
            ecnt_q   <= '0;
            last_q   <= '0;
            state_q  <= {ABSENT, ABSENT};
            streak_q <= '0;
            done_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            wcnt_q   <= wcnt_d;
            ecnt_q   <= ecnt_d;
            last_q   <= last_d;
            state_q  <= state_d;
            streak_q <= streak_d;
            done_q   <= done_d;
        end
    end

    // PRESENT and LOSING are the only encodings with bit 1 set
    assign bus.IR          = {state_q[1][1], state_q[0][1]};
    assign bus.window_done = done_q;
    assign bus.last_count  = last_q;
endmodule

// File: tb/tb_ir_beacon_detect.sv
// tb_ir_beacon_detect: directed per-window edge counts with a scoreboard of
// expected window results checked at every window_done.
module tb_ir_beacon_detect;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   since = 0;
    logic [1:0] cur_ir = 2'b00;

    typedef struct packed {
        logic [1:0]  ir;
        logic [15:0] last;
        logic [7:0]  last_s;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    ir_beacon_detect_if #(.CNT_W(8)) bus ();
    ir_beacon_detect_if #(.CNT_W(4)) bus_s ();

    ir_beacon_detect #(
        .GATE_CYCLES(100), .CNT_W(8), .EDGE_MIN(4), .EDGE_MAX(8),
        .HITS_REQ(3), .MISS_REQ(2)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    ir_beacon_detect #(
        .GATE_CYCLES(100), .CNT_W(4), .EDGE_MIN(4), .EDGE_MAX(8),
        .HITS_REQ(3), .MISS_REQ(2)
    ) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // one window of len cycles: n0/n1 one-cycle pulses spaced 3 cycles from cycle 5
    task automatic run_win(input int n0, input int n1, input int len,
                           input logic [1:0] ir, input bit push);
        exp_t e;
        logic [1:0] v;
        if (push) begin
            e.ir     = ir;
            e.last   = {8'(n1), 8'(n0)};
            e.last_s = {4'(n1 > 15 ? 15 : n1), 4'(n0 > 15 ? 15 : n0)};
            q.push_back(e);
        end
        for (int k = 0; k < len; k++) begin
            v[0] = k >= 5 && (k - 5) % 3 == 0 && (k - 5) / 3 < n0;
            v[1] = k >= 5 && (k - 5) % 3 == 0 && (k - 5) / 3 < n1;
            bus.ir_raw   = v;
            bus_s.ir_raw = v;
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        logic r;
        exp_t e;
        r = reset;
        #1;
        if (!r) begin
            since  = 0;
            cur_ir = 2'b00;
            chk("rst_ir", 32'(bus.IR), 0);
            chk("rst_done", 32'(bus.window_done), 0);
            chk("rst_last", 32'(bus.last_count), 0);
            chk("rst_last_s", 32'(bus_s.last_count), 0);
        end else begin
            since++;
            if (bus.window_done) begin
                chk("period", since, 100);
                since = 0;
                chk("done_s", 32'(bus_s.window_done), 1);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done act=1 exp=0 t=%0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("ir", 32'(bus.IR), 32'(e.ir));
                    chk("last", 32'(bus.last_count), 32'(e.last));
                    chk("last_s", 32'(bus_s.last_count), 32'(e.last_s));
                    chk("ir_s", 32'(bus_s.IR), 32'(e.ir));
                    cur_ir = e.ir;
                end
            end else begin
                chk("ir_hold", 32'(bus.IR), 32'(cur_ir));
                chk("done_s_idle", 32'(bus_s.window_done), 0);
                if (since == 150) chk("done_timeout", 0, 1);
            end
        end
    end

    initial begin
        bus.ir_raw   = 2'b00;
        bus_s.ir_raw = 2'b00;
        for (int k = 0; k < 10; k++) begin
            bus.ir_raw   = {1'b0, k[0]};
            bus_s.ir_raw = {1'b0, k[0]};
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        run_win(6, 0, 100, 2'b00, 1);
        run_win(6, 0, 100, 2'b00, 1);
        run_win(6, 0, 100, 2'b01, 1);
        run_win(6, 25, 100, 2'b01, 1);
        run_win(0, 2, 100, 2'b01, 1);
        run_win(7, 3, 100, 2'b01, 1);
        run_win(0, 0, 100, 2'b01, 1);
        run_win(0, 0, 100, 2'b00, 1);
        run_win(5, 9, 100, 2'b00, 1);
        run_win(5, 3, 100, 2'b00, 1);
        run_win(0, 4, 100, 2'b00, 1);
        run_win(4, 8, 100, 2'b00, 1);
        run_win(8, 4, 100, 2'b10, 1);
        run_win(6, 9, 100, 2'b11, 1);
        run_win(20, 0, 100, 2'b01, 1);
        run_win(20, 0, 100, 2'b00, 1);
        run_win(6, 6, 100, 2'b00, 1);
        run_win(6, 6, 100, 2'b00, 1);
        run_win(6, 6, 40, 2'b00, 0);
        reset        = 1'b0;
        bus.ir_raw   = 2'b00;
        bus_s.ir_raw = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_win(6, 6, 100, 2'b00, 1);
        run_win(6, 6, 100, 2'b00, 1);
        run_win(6, 6, 100, 2'b11, 1);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
